game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_if.sv | 26 ++
 rtl/game_sequencer.sv | 177 +++++++++++++++++
 tb/tb_game_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_if.sv
// Control/status bundle between the game sequencer and the game logic around it.
// The master drives the game events, and the slave (the sequencer) reports game state.
interface game_if;
  logic       start;
  logic       collision;
  logic       pellets_done;
  logic       power_pellet;
  logic [2:0] state;
  logic       freeze;
  logic       entity_reset;
  logic       lose_game;
  logic       win_game;
  logic [1:0] lives;
  logic [1:0] ghost_mode;
  logic       fright_flash;

  modport master (
    output start, collision, pellets_done, power_pellet,
    input  state, freeze, entity_reset, lose_game, win_game, lives, ghost_mode, fright_flash
  );

  modport slave (
    input  start, collision, pellets_done, power_pellet,
    output state, freeze, entity_reset, lose_game, win_game, lives, ghost_mode, fright_flash
  );
endinterface

// File: rtl/game_sequencer.sv
// Pac-Man round sequencer: IDLE/READY/PLAY/DYING/WIN/LOSE flow, lives, and ghost scatter/chase/fright
// scheduling, all paced by frame ticks derived from the asynchronous vertical sync.
module game_sequencer #(
  parameter int READY_FRAMES   = 120,
  parameter int DEATH_FRAMES   = 90,
  parameter int SCATTER_FRAMES = 420,
  parameter int CHASE_FRAMES   = 1200,
  parameter int FRIGHT_FRAMES  = 360,
  parameter int FLASH_FRAMES   = 120,
  parameter int START_LIVES    = 3
) (
  input  logic   Clk,
  input  logic   Reset,
  input  logic   frame_clk,
  game_if.slave  gif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_DYING = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_t;

  localparam logic [10:0] READY_LAST   = 11'(READY_FRAMES - 1);
  localparam logic [10:0] DEATH_LAST   = 11'(DEATH_FRAMES - 1);
  localparam logic [10:0] SCATTER_LAST = 11'(SCATTER_FRAMES - 1);
  localparam logic [10:0] CHASE_LAST   = 11'(CHASE_FRAMES - 1);
  localparam logic [10:0] FRIGHT_LOAD  = 11'(FRIGHT_FRAMES);
  localparam logic [10:0] FLASH_LIMIT  = 11'(FLASH_FRAMES);
  localparam logic [1:0]  LIVES_INIT   = 2'(START_LIVES);

  state_t      state_q, state_d;
  logic [2:0]  fc_sync_q;
  logic [10:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]  phase_q, phase_d;
  logic [10:0] phase_cnt_q, phase_cnt_d;
  logic [10:0] fright_cnt_q, fright_cnt_d;
  logic [1:0]  lives_q, lives_d;
  logic        ent_rst_q, ent_rst_d;
  logic        tick_s;
  logic        frightened_s;
  logic [10:0] phase_last_s;

  // Bits 0/1 are the synchronizer; bit 2 delays the synchronized level for rising-edge detection.
  assign tick_s       = fc_sync_q[1] & ~fc_sync_q[2];
  assign frightened_s = (fright_cnt_q != 11'd0);
  assign phase_last_s = phase_q[0] ? CHASE_LAST : SCATTER_LAST;

  // State register together with the counters, lives and the entity_reset pulse register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      fc_sync_q    <= 3'b000;
      frame_cnt_q  <= 11'd0;
      phase_q      <= 3'd0;
      phase_cnt_q  <= 11'd0;
      fright_cnt_q <= 11'd0;
      lives_q      <= LIVES_INIT;
      ent_rst_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fc_sync_q    <= {fc_sync_q[1:0], frame_clk};
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
      phase_cnt_q  <= phase_cnt_d;
      fright_cnt_q <= fright_cnt_d;
      lives_q      <= lives_d;
      ent_rst_q    <= ent_rst_d;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    phase_d      = phase_q;
    phase_cnt_d  = phase_cnt_q;
    fright_cnt_d = fright_cnt_q;
    lives_d      = lives_q;
    ent_rst_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gif.start) begin
          state_d      = S_READY;
          ent_rst_d    = 1'b1;
          frame_cnt_d  = 11'd0;
          phase_d      = 3'd0;
          phase_cnt_d  = 11'd0;
          fright_cnt_d = 11'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READY: begin
        if (tick_s) begin
          if (frame_cnt_q >= READY_LAST) begin
            state_d     = S_PLAY;
            frame_cnt_d = 11'd0;
          end else begin
            frame_cnt_d = frame_cnt_q + 11'd1;
          end
        end else begin
          frame_cnt_d = frame_cnt_q;
        end
      end
      S_PLAY: begin
        if (gif.pellets_done) begin
          state_d = S_WIN;
        end else if (gif.collision && !frightened_s) begin
          // Death cancels fright but leaves the phase and its timer where they were.
          state_d      = S_DYING;
          frame_cnt_d  = 11'd0;
          fright_cnt_d = 11'd0;
        end else if (gif.power_pellet) begin
          fright_cnt_d = FRIGHT_LOAD;
        end else if (tick_s) begin
          if (frightened_s) begin
            fright_cnt_d = fright_cnt_q - 11'd1;
          end else if (phase_q != 3'd7) begin
            if (phase_cnt_q >= phase_last_s) begin
              phase_d     = phase_q + 3'd1;
              phase_cnt_d = 11'd0;
            end else begin
              phase_cnt_d = phase_cnt_q + 11'd1;
            end
          end else begin
            phase_cnt_d = phase_cnt_q;
          end
        end else begin
          state_d = S_PLAY;
        end
      end
      S_DYING: begin
        if (tick_s) begin
          if (frame_cnt_q >= DEATH_LAST) begin
            frame_cnt_d = 11'd0;
            lives_d     = lives_q - 2'd1;
            if (lives_q <= 2'd1) begin
              state_d = S_LOSE;
            end else begin
              state_d   = S_READY;
              ent_rst_d = 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 11'd1;
          end
        end else begin
          frame_cnt_d = frame_cnt_q;
        end
      end
      S_WIN:   state_d = S_WIN;
      S_LOSE:  state_d = S_LOSE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    gif.state        = state_q;
    gif.freeze       = (state_q != S_PLAY);
    gif.entity_reset = ent_rst_q;
    gif.win_game     = (state_q == S_WIN);
    gif.lose_game    = (state_q == S_LOSE);
    gif.lives        = lives_q;
    if (frightened_s) begin
      gif.ghost_mode   = 2'd2;
      gif.fright_flash = (fright_cnt_q <= FLASH_LIMIT);
    end else begin
      gif.ghost_mode   = {1'b0, phase_q[0]};
      gif.fright_flash = 1'b0;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with small frame counts; vsync runs at 1/20 of Clk.
module tb_game_sequencer;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic frame_clk = 1'b0;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;

  game_if gif ();

  game_sequencer #(
    .READY_FRAMES(4), .DEATH_FRAMES(3), .SCATTER_FRAMES(5), .CHASE_FRAMES(6),
    .FRIGHT_FRAMES(4), .FLASH_FRAMES(2), .START_LIVES(2)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk(frame_clk),
    .gif(gif)
  );

  always #5 Clk = ~Clk;
  always #100 frame_clk = ~frame_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_clk(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Frame tick takes effect on the third Clk edge after each vsync rise.
  task automatic tick_wait(input int n);
    repeat (n) @(posedge frame_clk);
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic pulse_pellet();
    gif.power_pellet = 1'b1;
    step_clk(1);
    gif.power_pellet = 1'b0;
  endtask

  task automatic pulse_collision();
    gif.collision = 1'b1;
    step_clk(1);
    gif.collision = 1'b0;
  endtask

  task automatic start_game();
    tick_wait(1);
    gif.start = 1'b1;
    step_clk(1);
    gif.start = 1'b0;
  endtask

  initial begin
    gif.start = 1'b0;
    gif.collision = 1'b0;
    gif.pellets_done = 1'b0;
    gif.power_pellet = 1'b0;
    step_clk(3);
    check("rst_state", gif.state, 0);
    check("rst_freeze", gif.freeze, 1);
    check("rst_lives", gif.lives, 2);
    check("rst_mode", gif.ghost_mode, 0);
    check("rst_flash", gif.fright_flash, 0);
    check("rst_entrst", gif.entity_reset, 0);
    check("rst_win", gif.win_game, 0);
    check("rst_lose", gif.lose_game, 0);
    Reset = 1'b0;

    // Game A: start, full phase schedule, then win beats collision
    start_game();
    check("a_ready", gif.state, 1);
    check("a_entrst", gif.entity_reset, 1);
    step_clk(1);
    check("a_entrst_end", gif.entity_reset, 0);
    check("a_ready_freeze", gif.freeze, 1);
    tick_wait(3);
    check("a_ready_hold", gif.state, 1);
    tick_wait(1);
    check("a_play", gif.state, 2);
    check("a_play_freeze", gif.freeze, 0);
    check("a_ph0", gif.ghost_mode, 0);
    tick_wait(4);
    check("a_ph0_end", gif.ghost_mode, 0);
    tick_wait(1);
    check("a_ph1", gif.ghost_mode, 1);
    tick_wait(5);
    check("a_ph1_end", gif.ghost_mode, 1);
    tick_wait(1);
    check("a_ph2", gif.ghost_mode, 0);
    tick_wait(4);
    check("a_ph2_end", gif.ghost_mode, 0);
    tick_wait(1);
    check("a_ph3", gif.ghost_mode, 1);
    tick_wait(6);
    check("a_ph4", gif.ghost_mode, 0);
    tick_wait(5);
    check("a_ph5", gif.ghost_mode, 1);
    tick_wait(6);
    check("a_ph6", gif.ghost_mode, 0);
    tick_wait(5);
    check("a_ph7", gif.ghost_mode, 1);
    tick_wait(20);
    check("a_ph7_hold", gif.ghost_mode, 1);
    check("a_ph7_state", gif.state, 2);
    gif.collision = 1'b1;
    gif.pellets_done = 1'b1;
    step_clk(1);
    gif.collision = 1'b0;
    gif.pellets_done = 1'b0;
    check("a_win", gif.state, 4);
    check("a_win_game", gif.win_game, 1);
    check("a_win_lose", gif.lose_game, 0);
    check("a_win_lives", gif.lives, 2);
    check("a_win_freeze", gif.freeze, 1);
    tick_wait(2);
    check("a_win_hold", gif.state, 4);

    // Game B: fright, reload, collision ignored while frightened, two deaths
    Reset = 1'b1;
    step_clk(2);
    check("b_rst_state", gif.state, 0);
    check("b_rst_win", gif.win_game, 0);
    Reset = 1'b0;
    start_game();
    tick_wait(4);
    check("b_play", gif.state, 2);
    tick_wait(2);
    check("b_scatter", gif.ghost_mode, 0);
    pulse_pellet();
    check("b_fright", gif.ghost_mode, 2);
    check("b_flash_off", gif.fright_flash, 0);
    gif.collision = 1'b1;
    step_clk(2);
    gif.collision = 1'b0;
    check("b_fright_coll", gif.state, 2);
    tick_wait(1);
    check("b_flash_3", gif.fright_flash, 0);
    tick_wait(1);
    check("b_flash_2", gif.fright_flash, 1);
    check("b_mode_2", gif.ghost_mode, 2);
    tick_wait(1);
    pulse_pellet();
    check("b_reload_flash", gif.fright_flash, 0);
    check("b_reload_mode", gif.ghost_mode, 2);
    tick_wait(3);
    check("b_reload_still", gif.ghost_mode, 2);
    check("b_reload_flash1", gif.fright_flash, 1);
    tick_wait(1);
    check("b_fright_end", gif.ghost_mode, 0);
    check("b_fright_end_fl", gif.fright_flash, 0);
    tick_wait(1);
    check("b_scatter_rem", gif.ghost_mode, 0);
    pulse_collision();
    check("b_dying", gif.state, 3);
    check("b_dying_freeze", gif.freeze, 1);
    tick_wait(2);
    check("b_dying_hold", gif.state, 3);
    check("b_dying_lives", gif.lives, 2);
    tick_wait(1);
    check("b_redo_ready", gif.state, 1);
    check("b_lives1", gif.lives, 1);
    check("b_redo_entrst", gif.entity_reset, 1);
    step_clk(1);
    check("b_redo_entrst_end", gif.entity_reset, 0);
    tick_wait(4);
    check("b_replay", gif.state, 2);
    tick_wait(1);
    check("b_retained_sc", gif.ghost_mode, 0);
    tick_wait(1);
    check("b_retained_ch", gif.ghost_mode, 1);
    pulse_collision();
    check("b_dying2", gif.state, 3);
    tick_wait(3);
    check("b_lose", gif.state, 5);
    check("b_lose_game", gif.lose_game, 1);
    check("b_lose_lives", gif.lives, 0);
    check("b_lose_freeze", gif.freeze, 1);
    check("b_lose_entrst", gif.entity_reset, 0);
    tick_wait(1);
    check("b_lose_hold", gif.state, 5);

    // Game C: pellet ignored outside PLAY, reset in the middle of DYING
    Reset = 1'b1;
    step_clk(2);
    Reset = 1'b0;
    start_game();
    pulse_pellet();
    check("c_ready_pellet", gif.ghost_mode, 0);
    tick_wait(4);
    check("c_play", gif.state, 2);
    tick_wait(5);
    check("c_chase", gif.ghost_mode, 1);
    pulse_collision();
    check("c_dying", gif.state, 3);
    check("c_dying_mode", gif.ghost_mode, 1);
    pulse_pellet();
    check("c_dying_pellet", gif.ghost_mode, 1);
    tick_wait(1);
    Reset = 1'b1;
    step_clk(1);
    check("c_rst_state", gif.state, 0);
    check("c_rst_lives", gif.lives, 2);
    check("c_rst_mode", gif.ghost_mode, 0);
    check("c_rst_flash", gif.fright_flash, 0);
    check("c_rst_freeze", gif.freeze, 1);
    Reset = 1'b0;
    step_clk(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
